// File: rtl/video_src_sched.sv
// Frame-synchronous video source scheduler: queues source-switch requests and applies them at V start.
// Optional auto-cycle dwell timer is enabled by defining VSS_AUTO_CYCLE_EN.
module video_src_sched #(
  parameter int unsigned DWELL_FRAMES = 60,
  parameter int unsigned MIN_HOLD     = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       cen_i,
  input  logic [3:0] fvht_i,
  input  logic       req_i,
  input  logic       req_src_i,
  input  logic       auto_en_i,
  output logic       vid_sel_o,
  output logic       ack_o,
  output logic       pending_o,
  output logic       switch_o,
  output logic [7:0] frame_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_state_d;
  logic       r_v_d1;
  logic [7:0] r_frame_cnt;
  logic       r_vid_sel;
  logic       w_vid_sel_d;
  logic       r_target;
  logic       w_target_d;
  logic       r_queued;
  logic       w_queued_d;
  logic [3:0] r_hold_cnt;
  logic [3:0] w_hold_cnt_d;
  logic       r_ack;
  logic       r_switch;
  logic       w_switch_d;
  logic       w_vstart;
  logic       w_req;
  logic       w_tgt;
  logic       w_auto_go;
  logic       w_unused;

  assign w_vstart = cen_i & fvht_i[2] & ~r_v_d1;
  assign w_req    = cen_i & req_i;

  always_comb begin
    w_state_d    = r_state;
    w_vid_sel_d  = r_vid_sel;
    w_target_d   = r_target;
    w_queued_d   = r_queued;
    w_hold_cnt_d = r_hold_cnt;
    w_switch_d   = 1'b0;
    w_tgt        = w_req ? req_src_i : r_target;
    case (r_state)
      ST_IDLE: begin
        // A request in the same cycle as vstart only queues; it applies at the next frame.
        if (w_req) begin
          if (req_src_i != r_vid_sel) begin
            w_target_d = req_src_i;
            w_queued_d = 1'b1;
            w_state_d  = ST_PEND;
          end
        end else if (w_auto_go) begin
          w_target_d = ~r_vid_sel;
          w_queued_d = 1'b1;
          w_state_d  = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_tgt == r_vid_sel) begin
          w_state_d  = ST_IDLE;
          w_queued_d = 1'b0;
        end else if (w_vstart) begin
          w_vid_sel_d  = w_tgt;
          w_switch_d   = 1'b1;
          w_hold_cnt_d = 4'(MIN_HOLD);
          w_queued_d   = 1'b0;
          w_state_d    = ST_HOLD;
        end else begin
          w_target_d = w_tgt;
        end
      end
      ST_HOLD: begin
        if (w_req) begin
          w_target_d = req_src_i;
          w_queued_d = 1'b1;
        end
        if (w_vstart) begin
          if (r_hold_cnt <= 4'd1) begin
            w_hold_cnt_d = 4'd0;
            // A target equal to the current source is dropped rather than re-applied.
            if (w_queued_d && (w_target_d != r_vid_sel)) begin
              w_state_d = ST_PEND;
            end else begin
              w_state_d  = ST_IDLE;
              w_queued_d = 1'b0;
            end
          end else begin
            w_hold_cnt_d = r_hold_cnt - 4'd1;
          end
        end
      end
      default: begin
        w_state_d  = ST_IDLE;
        w_queued_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_v_d1      <= 1'b1;
      r_frame_cnt <= 8'd0;
      r_vid_sel   <= 1'b0;
      r_target    <= 1'b0;
      r_queued    <= 1'b0;
      r_hold_cnt  <= 4'd0;
      r_ack       <= 1'b0;
      r_switch    <= 1'b0;
    end else begin
      r_ack    <= w_req;
      r_switch <= w_switch_d;
      if (cen_i) begin
        r_state    <= w_state_d;
        r_v_d1     <= fvht_i[2];
        r_vid_sel  <= w_vid_sel_d;
        r_target   <= w_target_d;
        r_queued   <= w_queued_d;
        r_hold_cnt <= w_hold_cnt_d;
        if (w_vstart) begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
      end
    end
  end

`ifdef VSS_AUTO_CYCLE_EN
  logic [7:0] r_dwell;

  // Dwell is measured in frames since the last switch, so the hold frames count toward it.
  assign w_auto_go = auto_en_i & w_vstart & (r_state == ST_IDLE)
                   & (r_dwell == 8'(DWELL_FRAMES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dwell <= 8'd0;
    end else if (cen_i) begin
      if (w_req || w_switch_d || w_auto_go) begin
        r_dwell <= 8'd0;
      end else if (w_vstart && (r_state != ST_PEND)) begin
        r_dwell <= r_dwell + 8'd1;
      end
    end
  end

  assign w_unused = ^{fvht_i[3], fvht_i[1:0]};
`else
  assign w_auto_go = 1'b0;
  assign w_unused  = ^{auto_en_i, fvht_i[3], fvht_i[1:0], 8'(DWELL_FRAMES)};
`endif

  assign vid_sel_o   = r_vid_sel;
  assign ack_o       = r_ack;
  assign switch_o    = r_switch;
  assign frame_cnt_o = r_frame_cnt;
  assign pending_o   = (r_state == ST_PEND) | ((r_state == ST_HOLD) & r_queued);

endmodule

// File: tb/tb_video_src_sched.sv
// Scoreboard bench for video_src_sched (default build, auto-cycle disabled).
module tb_video_src_sched;

  logic       clk;
  logic       rst_n;
  logic       cen;
  logic [3:0] fvht;
  logic       req;
  logic       req_src;
  logic       auto_en;
  logic       vid_sel_o;
  logic       ack_o;
  logic       pending_o;
  logic       switch_o;
  logic [7:0] frame_cnt_o;

  typedef struct {
    logic       val;
    logic [7:0] frame;
  } sw_t;

  sw_t        sb_q[$];
  int         n_checks;
  int         n_errors;
  logic [7:0] exp_frame;
  logic [7:0] prev_cnt;
  logic       wrap_seen;

  video_src_sched #(
    .DWELL_FRAMES(60),
    .MIN_HOLD    (2)
  ) u_dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .cen_i      (cen),
    .fvht_i     (fvht),
    .req_i      (req),
    .req_src_i  (req_src),
    .auto_en_i  (auto_en),
    .vid_sel_o  (vid_sel_o),
    .ack_o      (ack_o),
    .pending_o  (pending_o),
    .switch_o   (switch_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every switch_o pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && switch_o) begin
      if (sb_q.size() == 0) begin
        check_eq("sw_spurious", 32'(vid_sel_o), 32'(~vid_sel_o));
      end else begin
        sw_t e;
        e = sb_q.pop_front();
        check_eq("sw_val", 32'(vid_sel_o), 32'(e.val));
        check_eq("sw_frame", 32'(frame_cnt_o), 32'(e.frame));
      end
    end
    if (rst_n && prev_cnt == 8'd255 && frame_cnt_o == 8'd0) wrap_seen = 1'b1;
    prev_cnt = frame_cnt_o;
  end

  task automatic frame(input logic with_req, input logic src);
    @(negedge clk);
    fvht[2] = 1'b1;
    if (with_req) begin
      req     = 1'b1;
      req_src = src;
    end
    if (cen) exp_frame = exp_frame + 8'd1;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    fvht[2] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_req(input logic src);
    @(negedge clk);
    req     = 1'b1;
    req_src = src;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic push_sw(input logic val, input logic [7:0] fr);
    sw_t e;
    e.val   = val;
    e.frame = fr;
    sb_q.push_back(e);
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    cen       = 1'b1;
    fvht      = 4'b0100;
    req       = 1'b0;
    req_src   = 1'b0;
    auto_en   = 1'b1;
    n_checks  = 0;
    n_errors  = 0;
    exp_frame = 8'd0;
    prev_cnt  = 8'd0;
    wrap_seen = 1'b0;

    // Reset values, then release during vertical blanking
    repeat (3) @(negedge clk);
    check_eq("rst_vid_sel", 32'(vid_sel_o), 32'd0);
    check_eq("rst_ack", 32'(ack_o), 32'd0);
    check_eq("rst_pending", 32'(pending_o), 32'd0);
    check_eq("rst_switch", 32'(switch_o), 32'd0);
    check_eq("rst_frame", 32'(frame_cnt_o), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rel_in_vblank_frame", 32'(frame_cnt_o), 32'd0);
    fvht[2] = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("no_vstart_before_edge", 32'(frame_cnt_o), 32'd0);
    frame(1'b0, 1'b0);
    check_eq("first_frame", 32'(frame_cnt_o), 32'(exp_frame));

    // Mid-frame request to colour
    pulse_req(1'b1);
    check_eq("req1_ack", 32'(ack_o), 32'd1);
    check_eq("req1_pending", 32'(pending_o), 32'd1);
    check_eq("req1_sel_before", 32'(vid_sel_o), 32'd0);
    @(negedge clk);
    check_eq("req1_ack_one_cycle", 32'(ack_o), 32'd0);
    push_sw(1'b1, exp_frame + 8'd1);
    frame(1'b0, 1'b0);
    check_eq("req1_sel_after", 32'(vid_sel_o), 32'd1);
    check_eq("hold_no_queue_pending", 32'(pending_o), 32'd0);

    // Request during hold waits for MIN_HOLD expiry: applies at 3rd vstart
    pulse_req(1'b0);
    check_eq("hold_req_ack", 32'(ack_o), 32'd1);
    check_eq("hold_req_pending", 32'(pending_o), 32'd1);
    push_sw(1'b0, exp_frame + 8'd3);
    frame(1'b0, 1'b0);
    check_eq("hold_f1_sel", 32'(vid_sel_o), 32'd1);
    frame(1'b0, 1'b0);
    check_eq("hold_f2_sel", 32'(vid_sel_o), 32'd1);
    check_eq("hold_f2_pending", 32'(pending_o), 32'd1);
    frame(1'b0, 1'b0);
    check_eq("hold_f3_sel", 32'(vid_sel_o), 32'd0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    check_eq("back_idle_pending", 32'(pending_o), 32'd0);

    // Cancel in PEND by requesting the current source
    pulse_req(1'b1);
    check_eq("cancel_pend_set", 32'(pending_o), 32'd1);
    pulse_req(1'b0);
    check_eq("cancel_ack", 32'(ack_o), 32'd1);
    check_eq("cancel_pending", 32'(pending_o), 32'd0);
    frame(1'b0, 1'b0);
    check_eq("cancel_sel", 32'(vid_sel_o), 32'd0);
    check_eq("cancel_frame", 32'(frame_cnt_o), 32'(exp_frame));

    // Request coincident with vstart in IDLE applies one frame later
    frame(1'b1, 1'b1);
    check_eq("coinc_idle_pending", 32'(pending_o), 32'd1);
    check_eq("coinc_idle_sel", 32'(vid_sel_o), 32'd0);
    push_sw(1'b1, exp_frame + 8'd1);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);

    // PEND: request coincident with vstart wins (cancel, then apply)
    pulse_req(1'b0);
    frame(1'b1, 1'b1);
    check_eq("coinc_pend_cancel_sel", 32'(vid_sel_o), 32'd1);
    check_eq("coinc_pend_cancel_pending", 32'(pending_o), 32'd0);
    pulse_req(1'b0);
    push_sw(1'b0, exp_frame + 8'd1);
    frame(1'b1, 1'b0);
    check_eq("coinc_pend_apply_sel", 32'(vid_sel_o), 32'd0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);

    // Same-source request in IDLE: ack only
    pulse_req(1'b0);
    check_eq("same_src_ack", 32'(ack_o), 32'd1);
    check_eq("same_src_pending", 32'(pending_o), 32'd0);

    // cen_i=0 freezes state and suppresses pulses
    @(negedge clk);
    cen = 1'b0;
    pulse_req(1'b1);
    check_eq("cen0_ack", 32'(ack_o), 32'd0);
    check_eq("cen0_pending", 32'(pending_o), 32'd0);
    cen = 1'b1;
    pulse_req(1'b1);
    cen = 1'b0;
    frame(1'b0, 1'b0);
    check_eq("freeze_pending", 32'(pending_o), 32'd1);
    check_eq("freeze_sel", 32'(vid_sel_o), 32'd0);
    check_eq("freeze_frame", 32'(frame_cnt_o), 32'(exp_frame));
    cen = 1'b1;
    push_sw(1'b1, exp_frame + 8'd1);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);

    // 300 frames with cen toggling; every 10th frame fully disabled
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        fvht[2] = (c < 4);
        if (i % 10 == 9) cen = 1'b0;
        else if (i % 2 == 0) cen = (c % 2 == 1);
        else cen = (c % 2 == 0);
      end
      if (i % 10 != 9) exp_frame = exp_frame + 8'd1;
    end
    @(negedge clk);
    cen     = 1'b1;
    fvht[2] = 1'b0;
    @(negedge clk);
    check_eq("cen_toggle_frame", 32'(frame_cnt_o), 32'(exp_frame));
    check_eq("cen_toggle_wrap", 32'(wrap_seen), 32'd1);
    check_eq("no_auto_toggle_sel", 32'(vid_sel_o), 32'd1);

    // Reset during PEND discards the queued target
    pulse_req(1'b0);
    check_eq("pre_rst_pending", 32'(pending_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    exp_frame = 8'd0;
    @(negedge clk);
    check_eq("mid_rst_pending", 32'(pending_o), 32'd0);
    check_eq("mid_rst_frame", 32'(frame_cnt_o), 32'd0);
    rst_n = 1'b1;
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    check_eq("post_rst_sel", 32'(vid_sel_o), 32'd0);
    check_eq("post_rst_frame", 32'(frame_cnt_o), 32'(exp_frame));

    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_src_sched.md
VIDEO_SRC_SCHED -- requirements
Module: video_src_sched

Interface
REQ-001 SHALL have parameter DWELL_FRAMES, default 60, frames per source in auto-cycle mode (range 1..255).
REQ-002 SHALL have parameter MIN_HOLD, default 2, minimum frames after any switch before the next switch (range 1..15).
REQ-003 SHALL have port clk_i, input, 1, single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port cen_i, input, 1, clock enable qualifying every state, counter and edge-detect update.
REQ-006 SHALL have port fvht_i, input, 4, timing {F,V,H,T}; bit 2 = V, high during vertical blanking.
REQ-007 SHALL have port req_i, input, 1, single-cycle manual switch request (valid only when cen_i=1).
REQ-008 SHALL have port req_src_i, input, 1, requested source (0 = bars, 1 = colour), sampled with req_i.
REQ-009 SHALL have port auto_en_i, input, 1, auto-cycle enable (used only with VSS_AUTO_CYCLE_EN).
REQ-010 SHALL have port vid_sel_o, output, 1, registered source select driving the video datapath mux.
REQ-011 SHALL have port ack_o, output, 1, one-cycle pulse, request accepted.
REQ-012 SHALL have port pending_o, output, 1, high while a switch is queued.
REQ-013 SHALL have port switch_o, output, 1, one-cycle pulse coincident with vid_sel_o change.
REQ-014 SHALL have port frame_cnt_o, output, 8, free-running frame counter.

Function
REQ-015 SHALL detect frame start vstart = cen_i & fvht_i[2] & ~v_d1, where v_d1 is fvht_i[2] registered under cen_i.
REQ-016 SHALL increment frame_cnt_o on each vstart, wrapping 255->0.
REQ-017 SHALL implement FSM states IDLE, PEND, HOLD.
REQ-018 IDLE: on req_i with req_src_i != vid_sel_o, latch target, pulse ack_o next cycle, go PEND; with req_src_i == vid_sel_o, pulse ack_o, stay IDLE.
REQ-019 PEND: on vstart, load vid_sel_o <= target, pulse switch_o, load hold counter with MIN_HOLD, go HOLD; vid_sel_o changes only here.
REQ-020 PEND: a new req_i overwrites target (latest wins) and pulses ack_o; if the new target equals vid_sel_o, return to IDLE, no switch.
REQ-021 HOLD: decrement hold counter on each vstart; on reaching 0, go PEND if a target is queued, else IDLE.
REQ-022 HOLD: req_i is latched as target with ack_o and pending_o=1, but never applied before hold expiry.
REQ-023 req_i coincident with vstart in IDLE SHALL queue and apply at the next vstart, not the current one.
REQ-024 req_i and vstart in the same cycle in PEND SHALL apply the new req_src_i.
REQ-025 pending_o SHALL equal (state==PEND) or (HOLD with target queued).
REQ-026 cen_i=0 SHALL freeze all state; outputs hold values, pulses deassert.
REQ-027 Switch latency: vid_sel_o updates on the clk_i edge that samples vstart, i.e. 1 enabled cycle after V rises at fvht_i.

Reset
REQ-028 While rst_n_i=0: vid_sel_o=0, ack_o=0, pending_o=0, switch_o=0, frame_cnt_o=0, v_d1=1, state IDLE, counters 0, no target queued.
REQ-029 v_d1 reset to 1 SHALL suppress a false vstart if reset releases during blanking.
REQ-030 Reset mid-PEND/HOLD SHALL discard the queued target; no switch_o after release.

Configuration
REQ-031 With VSS_AUTO_CYCLE_EN defined: an 8-bit dwell counter counts vstart in IDLE; when it reaches DWELL_FRAMES-1 with auto_en_i=1, it queues ~vid_sel_o internally (no ack_o) and enters PEND; any manual req_i or switch clears it.
REQ-032 Without VSS_AUTO_CYCLE_EN: no dwell counter, auto_en_i ignored, switching only via req_i.

Verification
REQ-033 Reset release with fvht_i[2]=1 -> no switch_o, frame_cnt_o stays 0 until the next V rising edge.
REQ-034 req_i=1, req_src_i=1 mid-frame -> ack_o next cycle, pending_o=1; at next V rise vid_sel_o 0->1 with switch_o pulse.
REQ-035 Second req_src_i=0 during HOLD with MIN_HOLD=2 -> ack_o, switch applied at 3rd vstart after first switch.
REQ-036 In PEND, req_src_i=0 while vid_sel_o=0 -> ack_o, pending_o=0, no switch_o at vstart.
REQ-037 Toggle cen_i 50% over 300 frames -> frame_cnt_o wraps 255->0 and counts only enabled edges.
REQ-038 With VSS_AUTO_CYCLE_EN, DWELL_FRAMES=4, auto_en_i=1 -> vid_sel_o toggles every 5 frames; without macro, no toggles.
